motoro3_line_pwm_player: RTL and testbench
==========================================

# motoro3_line_pwm_player

Sequential consumer of the motor line-calculation parameters. Drives `lcStep` into the combinational parameter calculator, samples the returned `plLen` (PWM high length) and `slLen` (PWM periods per step) and plays them out as a PWM waveform. It steps through one electrical line of `LC_STEPS` steps, then wraps. It sits between the parameter calculator and the gate-driver output stage.

## Interface
Parameters:
- `LC_STEPS`, 12: steps per electrical line; `lcStep` runs 0..LC_STEPS-1 (max 16).
- `PER_W`, 16: width of the period counter and of `perLen`, `plLen` and `slLen`.

Ports:
- `clk` in 1: system clock; everything is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `enable` in 1: run request, level-sensitive.
- `perLen` in 16: PWM period in clocks; a value of 0 is treated as 1.
- `plLen` in 16: high length from the calculator, valid for the current `lcStep`.
- `slLen` in 16: PWM periods for the current step; a value of 0 is treated as 1.
- `lcStep` out 4: step index presented to the calculator, registered.
- `pwmOut` out 1: PWM output, registered.
- `stepDone` out 1: one-cycle pulse on the last clock of each step.
- `lineDone` out 1: one-cycle pulse on the last clock of step LC_STEPS-1 (coincides with `stepDone`).
- `busy` out 1: high when the state is not IDLE.

## Operation
- States:
  - IDLE: outputs quiet.
  - LOAD: one cycle in which the calculator settles on the new `lcStep`.
  - RUN: the waveform plays out.
- IDLE → LOAD when `enable`=1.
- LOAD → RUN unconditionally. At the LOAD→RUN edge the block latches:
  - `plQ` ← `plLen`
  - `slQ` ← max(`slLen`, 1)
  - `perQ` ← max(`perLen`, 1)
- RUN behaviour:
  - `perCnt` counts 0..perQ-1.
  - At `perCnt`=perQ-1 the block increments `slCnt`.
  - At `slCnt`=slQ-1 together with `perCnt`=perQ-1 the step ends.
- Step end:
  - `stepDone` pulses.
  - `lcStep` advances by one, wrapping from LC_STEPS-1 to 0; `lineDone` pulses at the wrap.
  - The state returns to LOAD.
- `pwmOut` is registered from (state==RUN && `perCnt` < `plQ`):
  - `plQ`=0 gives constant low.
  - `plQ` ≥ `perQ` gives constant high, with no glitch at the period boundary.
- `enable` falling during LOAD or RUN forces IDLE on the next edge:
  - `pwmOut`=0 and the counters clear.
  - `lcStep` holds its value, so the next enable resumes from the same step.
- Input changes during RUN are ignored, because the parameters are latched once per step.
- Arithmetic: all compares are unsigned on PER_W bits. The counters never exceed their terminal value, so there is no overflow.

## Timing
- Reset values:
  - `lcStep`=0, `pwmOut`=0, `stepDone`=0, `lineDone`=0, `busy`=0.
  - State is IDLE; all counters and latches are 0.
- `enable` rising at edge N: LOAD at N+1, RUN at N+2. First `pwmOut`=1 appears at edge N+3 if `plQ`>0.
- Step length = 1 (LOAD) + slQ·perQ clocks. There is no gap between periods inside a step.
- `pwmOut` lags the `perCnt` compare by one register stage. The same lag applies to every period.
- Reset asserted mid-step: all outputs take their reset values immediately, with no clock required.

## Configuration
- `MOTORO3_LINE_DIR_EN`: compiled in, it adds input `dir` (1 bit).
  - `dir`=1 decrements `lcStep`, wrapping from 0 to LC_STEPS-1; `lineDone` pulses at that wrap.
  - `dir` is sampled only at step end.
- Without the macro there is no `dir` port and stepping is increment-only.

## Structure
- Package `motoro3_pkg` holds:
  - the state enum (IDLE, LOAD, RUN);
  - `LC_STEP_MAX`=16;
  - the width constants shared with the calculator (`PWM_W`=8, `LEN_W`=16).
- Sub-module `motoro3_pwm_period_cnt`:
  - Inputs: `perQ`, `plQ`, `clr`, `run`.
  - Outputs: `perCnt`, a period-wrap pulse and a registered `pwmOut`.
  - The top level owns the FSM, `slCnt` and `lcStep`.

## Test plan
- Reset release, `enable`=1, `perLen`=10, `plLen`=3, `slLen`=2 → pwmOut pattern 3 high / 7 low ×2; `stepDone` 21 clocks after LOAD entry; `lcStep`=1.
- Run 12 full steps with LC_STEPS=12 → `lineDone` pulses exactly once, on the step 11→0 transition, coincident with `stepDone`.
- `plLen`=0, then `plLen`=20 with `perLen`=10 → `pwmOut` constant 0, then constant 1 across the period boundaries.
- `slLen`=0, `perLen`=0 → treated as 1/1; step length = 2 clocks.
- Deassert `enable` mid-RUN at `lcStep`=5 → IDLE next edge, `pwmOut`=0; re-enable → LOAD with `lcStep`=5. Assert `rst` mid-RUN → all outputs 0 asynchronously.
- With `MOTORO3_LINE_DIR_EN` and `dir`=1 from `lcStep`=0 → next `lcStep`=11 and `lineDone` pulses.

Source files
------------

// File: rtl/motoro3_pkg.sv
// Shared types and constants for the motoro3 line-calculation / PWM blocks.
package motoro3_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam int unsigned LC_STEP_MAX = 16;
    localparam int unsigned LC_STEP_W   = $clog2(LC_STEP_MAX);

    // Widths shared with the parameter calculator.
    localparam int unsigned PWM_W = 8;
    localparam int unsigned LEN_W = 16;

endpackage

// File: rtl/motoro3_line_pwm_player_if.sv
// Calculator-side bus of the line PWM player; `dir` exists only with MOTORO3_LINE_DIR_EN.
interface motoro3_line_pwm_player_if
    import motoro3_pkg::*;
#(
    parameter int unsigned PER_W = 16
) ();

    logic                 enable;
    logic [PER_W-1:0]     perLen;
    logic [PER_W-1:0]     plLen;
    logic [PER_W-1:0]     slLen;
`ifdef MOTORO3_LINE_DIR_EN
    logic                 dir;
`endif
    logic [LC_STEP_W-1:0] lcStep;
    logic                 pwmOut;
    logic                 stepDone;
    logic                 lineDone;
    logic                 busy;

`ifdef MOTORO3_LINE_DIR_EN
    modport master (output enable, perLen, plLen, slLen, dir,
                    input  lcStep, pwmOut, stepDone, lineDone, busy);
    modport slave  (input  enable, perLen, plLen, slLen, dir,
                    output lcStep, pwmOut, stepDone, lineDone, busy);
`else
    modport master (output enable, perLen, plLen, slLen,
                    input  lcStep, pwmOut, stepDone, lineDone, busy);
    modport slave  (input  enable, perLen, plLen, slLen,
                    output lcStep, pwmOut, stepDone, lineDone, busy);
`endif

endinterface

// File: rtl/motoro3_pwm_period_cnt.sv
// PWM period counter: counts 0..perQ-1 while running and registers the high/low compare.
module motoro3_pwm_period_cnt #(
    parameter int unsigned PER_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PER_W-1:0] perQ,
    input  logic [PER_W-1:0] plQ,
    input  logic             clr,
    input  logic             run,
    output logic [PER_W-1:0] perCnt,
    output logic             wrap,
    output logic             pwmOut
);

    logic [PER_W-1:0] cnt_q;
    logic             pwm_q;

    always_comb wrap = run && (cnt_q == perQ - PER_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            if (clr || wrap) begin
                cnt_q <= '0;
            end else if (run) begin
                cnt_q <= cnt_q + PER_W'(1);
            end
            // plQ >= perQ keeps this true on every count, so no dip at the wrap.
            pwm_q <= run && (cnt_q < plQ);
        end
    end

    assign perCnt = cnt_q;
    assign pwmOut = pwm_q;

endmodule

// File: rtl/motoro3_line_pwm_player.sv
// Steps lcStep through one electrical line and plays each step's PWM parameters.
// Optional MOTORO3_LINE_DIR_EN adds a `dir` input for decrementing steps.
module motoro3_line_pwm_player
    import motoro3_pkg::*;
#(
    parameter int unsigned LC_STEPS = 12,
    parameter int unsigned PER_W    = LEN_W
) (
    input logic                           clk,
    input logic                           rst,
    motoro3_line_pwm_player_if.slave      bus
);

    localparam logic [LC_STEP_W-1:0] LC_LAST = LC_STEP_W'(LC_STEPS - 1);

    state_t               state_q, state_d;
    logic [PER_W-1:0]     plQ, slQ, perQ, slCnt;
    logic [PER_W-1:0]     perCnt;
    logic [LC_STEP_W-1:0] lc_q, step_nxt;
    logic                 run, clr, wrap, pwm, last_sl, step_end, wrap_pt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state; dropping enable always wins over a step end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.enable) state_d = LOAD;
            LOAD:    state_d = bus.enable ? RUN : IDLE;
            RUN: begin
                if (!bus.enable)   state_d = IDLE;
                else if (step_end) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath controls
    always_comb begin
        run          = (state_q == RUN) && bus.enable;
        clr          = !run;
        last_sl      = (slCnt == slQ - PER_W'(1));
        step_end     = run && (perCnt == perQ - PER_W'(1)) && last_sl;
        bus.busy     = (state_q != IDLE);
        bus.stepDone = step_end;
        bus.lineDone = step_end && wrap_pt;
        bus.lcStep   = lc_q;
        bus.pwmOut   = pwm;
    end

    always_comb begin
        wrap_pt  = (lc_q == LC_LAST);
        step_nxt = wrap_pt ? '0 : lc_q + 1'b1;
`ifdef MOTORO3_LINE_DIR_EN
        if (bus.dir) begin
            wrap_pt  = (lc_q == '0);
            step_nxt = wrap_pt ? LC_LAST : lc_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            plQ   <= '0;
            slQ   <= '0;
            perQ  <= '0;
            slCnt <= '0;
            lc_q  <= '0;
        end else begin
            if (state_q == LOAD && bus.enable) begin
                plQ  <= bus.plLen;
                slQ  <= (bus.slLen == '0) ? PER_W'(1) : bus.slLen;
                perQ <= (bus.perLen == '0) ? PER_W'(1) : bus.perLen;
            end
            if (clr)       slCnt <= '0;
            else if (wrap) slCnt <= last_sl ? '0 : slCnt + PER_W'(1);
            if (step_end) lc_q <= step_nxt;
        end
    end

    motoro3_pwm_period_cnt #(
        .PER_W (PER_W)
    ) u_period (
        .clk    (clk),
        .rst    (rst),
        .perQ   (perQ),
        .plQ    (plQ),
        .clr    (clr),
        .run    (run),
        .perCnt (perCnt),
        .wrap   (wrap),
        .pwmOut (pwm)
    );

endmodule

// File: tb/tb_motoro3_line_pwm_player.sv
// Scoreboard bench for motoro3_line_pwm_player: expected per-step results are queued by the
// driver and checked by a monitor on every stepDone pulse.
module tb_motoro3_line_pwm_player;

    localparam int LC = 12;

    typedef struct {
        int lc;
        int line;
        int len;
        int hi;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cur    = 0;
    int   m_len  = 0;
    int   m_hi   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    motoro3_line_pwm_player_if #(.PER_W(16)) dif ();

    motoro3_line_pwm_player #(
        .LC_STEPS (LC),
        .PER_W    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: step window runs from LOAD entry to the stepDone cycle inclusive.
    always @(negedge clk) begin
        if (rst || !dif.busy) begin
            m_len = 0;
            m_hi  = 0;
        end else begin
            m_len++;
            m_hi += int'(dif.pwmOut);
            if (dif.stepDone) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step: got stepDone at lcStep %0d expected none",
                             dif.lcStep);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("step_lcstep", int'(dif.lcStep), e.lc);
                    chk("step_linedone", int'(dif.lineDone), e.line);
                    chk("step_len", m_len, e.len);
                    chk("step_pwm_highs", m_hi, e.hi);
                end
                m_len = 0;
                m_hi  = 0;
            end
        end
    end

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending steps expected 0", exp_q.size());
        exp_q.delete();
    endtask

    task automatic run_steps(input int n, input int per, input int pl, input int sl,
                             input int len, input int hi_first, input int hi_rest);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{cur, (cur == LC - 1) ? 1 : 0, len, (i == 0) ? hi_first : hi_rest});
            cur = (cur + 1) % LC;
        end
        dif.perLen = 16'(per);
        dif.plLen  = 16'(pl);
        dif.slLen  = 16'(sl);
        dif.enable = 1'b1;
        wait_drain(n * len + 20);
        dif.enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lcstep_after_run", int'(dif.lcStep), cur);
    endtask

    initial begin
        rst        = 1'b1;
        dif.enable = 1'b0;
        dif.perLen = '0;
        dif.plLen  = '0;
        dif.slLen  = '0;
`ifdef MOTORO3_LINE_DIR_EN
        dif.dir    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcstep", int'(dif.lcStep), 0);
        chk("rst_pwm", int'(dif.pwmOut), 0);
        chk("rst_stepdone", int'(dif.stepDone), 0);
        chk("rst_linedone", int'(dif.lineDone), 0);
        chk("rst_busy", int'(dif.busy), 0);
        rst = 1'b0;

        // 3 high / 7 low twice; 21-clock step
        run_steps(1, 10, 3, 2, 21, 6, 6);
        // Full line: lineDone only on the 11 -> 0 step
        run_steps(LC, 2, 1, 1, 3, 1, 1);
        // Constant low, then constant high across period boundaries
        run_steps(1, 10, 0, 2, 21, 0, 0);
        run_steps(2, 10, 20, 3, 31, 29, 30);
        // Zero lengths treated as 1
        run_steps(1, 0, 1, 0, 2, 0, 0);

        // Abort mid-RUN at lcStep 5, then resume from the same step
        dif.perLen = 16'd10;
        dif.plLen  = 16'd3;
        dif.slLen  = 16'd2;
        dif.enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_pre_pwm", int'(dif.pwmOut), 1);
        dif.enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", int'(dif.busy), 0);
        chk("abort_pwm", int'(dif.pwmOut), 0);
        chk("abort_lcstep", int'(dif.lcStep), 5);
        exp_q.push_back('{5, 0, 21, 6});
        cur        = 6;
        dif.enable = 1'b1;
        @(posedge clk);
        #1;
        chk("resume_busy", int'(dif.busy), 1);
        chk("resume_lcstep", int'(dif.lcStep), 5);
        wait_drain(60);
        dif.enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("resume_lcstep_after", int'(dif.lcStep), cur);

        // Asynchronous reset mid-RUN
        dif.enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("prerst_busy", int'(dif.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_lcstep", int'(dif.lcStep), 0);
        chk("arst_pwm", int'(dif.pwmOut), 0);
        chk("arst_stepdone", int'(dif.stepDone), 0);
        chk("arst_linedone", int'(dif.lineDone), 0);
        chk("arst_busy", int'(dif.busy), 0);
        dif.enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur = 0;

`ifdef MOTORO3_LINE_DIR_EN
        // Decrement from step 0 wraps to LC-1 with lineDone
        dif.dir = 1'b1;
        exp_q.push_back('{0, 1, 3, 1});
        dif.perLen = 16'd2;
        dif.plLen  = 16'd1;
        dif.slLen  = 16'd1;
        dif.enable = 1'b1;
        wait_drain(30);
        dif.enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("dir_lcstep", int'(dif.lcStep), LC - 1);
`else
        run_steps(1, 2, 1, 1, 3, 1, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
